// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: owns the PC, issues one imem request at a time,
// parks an unconsumable response in a one-entry skid and fills the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        flush_ifid,
  input  logic        stall_if,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr
);

  localparam logic [1:0]  S_REQ  = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd1;
  localparam logic [1:0]  S_FULL = 2'd2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic        accept;
  logic        load;
  logic [31:0] load_pc, load_instr;

  assign accept         = !ifid_valid_q || !stall_if;
  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_req_addr  = {pc_q[31:2], 2'b00};
  assign ifid_valid     = ifid_valid_q;
  assign ifid_pc        = ifid_pc_q;
  assign ifid_instr     = ifid_instr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    load         = 1'b0;
    load_pc      = skid_pc_q;
    load_instr   = skid_instr_q;

    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
          // the old-pc request is already in flight, so its response must be eaten
          if (redirect_valid) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          drop_d  = 1'b0;
          state_d = S_REQ;
          if (!drop_q && !redirect_valid) begin
            pc_d = req_pc_q + 32'd4;
            if (accept) begin
              load       = 1'b1;
              load_pc    = req_pc_q;
              load_instr = imem_resp_data;
            end else begin
              skid_pc_d    = req_pc_q;
              skid_instr_d = imem_resp_data;
              state_d      = S_FULL;
            end
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (accept) begin
          load    = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
  end

  // flush beats load beats hold; a non-stalled, unreloaded entry drains
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (flush_ifid) begin
      ifid_valid_d = 1'b0;
    end else if (load) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = load_pc;
      ifid_instr_d = load_instr;
    end else if (!stall_if) begin
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0;
      drop_q       <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      drop_q       <= drop_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order imem model of configurable latency.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid, flush_ifid, stall_if;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_instr;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        pend;
  logic [31:0] paddr;
  int          cnt, lat;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .stall_if(stall_if),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: sample handshake before the edge, advance the memory model after it
  task automatic tick();
    logic        hs, rv;
    logic [31:0] ha;
    hs = imem_req_valid && imem_req_ready;
    ha = imem_req_addr;
    rv = imem_resp_valid;
    @(posedge clk); #1;
    if (rv) pend = 1'b0;
    if (hs) begin
      pend  = 1'b1;
      paddr = ha;
      cnt   = lat - 1;
    end else if (pend && cnt > 0) begin
      cnt--;
    end
    imem_resp_valid = pend && (cnt == 0);
    imem_resp_data  = pend ? f(paddr) : 32'h0;
  endtask

  task automatic redir_tick(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    flush_ifid     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    flush_ifid     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; flush_ifid = 1'b0;
    stall_if = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    pend = 1'b0; paddr = 32'h0; cnt = 0; lat = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    chk("rst_ifid_instr", ifid_instr, 32'h13);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    rst = 1'b0;
    #1;
    chk("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    tick();
    chk("wait_no_req", {31'h0, imem_req_valid}, 32'h0);
    tick();
    chk("if0_valid", {31'h0, ifid_valid}, 32'h1);
    chk("if0_pc", ifid_pc, 32'h0);
    chk("if0_instr", ifid_instr, f(32'h0));
    chk("req_addr_4", imem_req_addr, 32'h4);

    // steady stream: one instruction every two cycles, no skips
    for (int a = 4; a <= 32'h10; a += 4) begin
      tick();
      chk("bubble", {31'h0, ifid_valid}, 32'h0);
      tick();
      chk("seq_pc", ifid_pc, a);
      chk("seq_instr", ifid_instr, f(a));
    end

    // decode back-pressure: 0x10 held, 0x14 parked in skid, no new request
    stall_if = 1'b1;
    repeat (5) begin
      tick();
      chk("stall_hold_pc", ifid_pc, 32'h10);
      chk("stall_hold_valid", {31'h0, ifid_valid}, 32'h1);
      chk("stall_no_req", {31'h0, imem_req_valid}, 32'h0);
    end
    stall_if = 1'b0;
    tick();
    chk("skid_pc", ifid_pc, 32'h14);
    chk("skid_instr", ifid_instr, f(32'h14));
    chk("skid_valid", {31'h0, ifid_valid}, 32'h1);
    chk("after_skid_req", {31'h0, imem_req_valid}, 32'h1);
    chk("after_skid_addr", imem_req_addr, 32'h18);
    repeat (4) tick();
    chk("pc_1c", ifid_pc, 32'h1C);
    chk("req_addr_20", imem_req_addr, 32'h20);

    // redirect while waiting on a slow response for 0x20
    lat = 3;
    tick();
    redir_tick(32'h200);
    chk("rd_wait_no_req", {31'h0, imem_req_valid}, 32'h0);
    tick();
    chk("rd_wait_no_req2", {31'h0, imem_req_valid}, 32'h0);
    tick();
    chk("rd_new_req", {31'h0, imem_req_valid}, 32'h1);
    chk("rd_new_addr", imem_req_addr, 32'h200);
    chk("rd_stale_dropped", {31'h0, ifid_valid}, 32'h0);
    lat = 1;
    repeat (2) tick();
    chk("rd_ifid_valid", {31'h0, ifid_valid}, 32'h1);
    chk("rd_ifid_pc", ifid_pc, 32'h200);
    chk("rd_ifid_instr", ifid_instr, f(32'h200));

    // redirect in S_REQ with no handshake stays in S_REQ
    imem_req_ready = 1'b0;
    redir_tick(32'h40);
    imem_req_ready = 1'b1;
    chk("rq_nohs_addr", imem_req_addr, 32'h40);
    chk("rq_nohs_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("flush_clears", {31'h0, ifid_valid}, 32'h0);

    // redirect coincident with the response for 0x40
    tick();
    redir_tick(32'h300);
    chk("co_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("co_req_addr", imem_req_addr, 32'h300);
    chk("co_no_load", {31'h0, ifid_valid}, 32'h0);
    repeat (2) tick();
    chk("co_ifid_valid", {31'h0, ifid_valid}, 32'h1);
    chk("co_ifid_pc", ifid_pc, 32'h300);

    // redirect on a handshake cycle; unaligned target is cleared
    redir_tick(32'h0000_0103);
    chk("hs_rd_wait", {31'h0, imem_req_valid}, 32'h0);
    tick();
    chk("hs_rd_req", {31'h0, imem_req_valid}, 32'h1);
    chk("align_addr", imem_req_addr, 32'h100);
    chk("hs_rd_dropped", {31'h0, ifid_valid}, 32'h0);
    repeat (2) tick();
    chk("align_ifid_pc", ifid_pc, 32'h100);
    chk("align_ifid_instr", ifid_instr, f(32'h100));

    // PC wrap
    imem_req_ready = 1'b0;
    redir_tick(32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    repeat (2) tick();
    chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imem_req_addr, 32'h0);

    // flush alone overrides a stall hold; an empty IF/ID still accepts under stall
    stall_if = 1'b1; flush_ifid = 1'b1;
    tick();
    flush_ifid = 1'b0;
    chk("flush_over_hold", {31'h0, ifid_valid}, 32'h0);
    tick();
    chk("stall_empty_load", {31'h0, ifid_valid}, 32'h1);
    chk("stall_empty_pc", ifid_pc, 32'h0);
    stall_if = 1'b0;

    // asynchronous reset pulse between edges while waiting
    lat = 3;
    tick();
    #3 rst = 1'b1;
    #1;
    chk("arst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
    chk("arst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("arst_ifid_instr", ifid_instr, 32'h13);
    pend = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_req_after", {31'h0, imem_req_valid}, 32'h1);
    chk("arst_addr_after", imem_req_addr, 32'h0);
    lat = 1;
    repeat (2) tick();
    chk("arst_ifid_pc", ifid_pc, 32'h0);
    chk("arst_ifid_valid2", {31'h0, ifid_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
